lru_refill_ctrl: RTL and testbench



---
 rtl/lru_refill_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lru_refill_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lru_refill_ctrl.sv
// Miss/refill sequencer that owns the LRU update port and arbitrates it against lookup hit updates.
// Define LRU_REFILL_PERF_EN to add saturating miss and writeback counters.
module lru_refill_ctrl #(
  parameter int ASSOCIATIVITY = 4,
  parameter int INDEX_BITS    = 8,
  parameter int OUTPUT_BITS   = 2,
  parameter int TAG_BITS      = 20,
  parameter int LINE_BITS     = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_valid,
  output logic                           miss_ready,
  input  logic [INDEX_BITS-1:0]          miss_index,
  input  logic [TAG_BITS-1:0]            miss_tag,
  output logic                           miss_done,
  input  logic                           hit_upd_valid,
  input  logic [INDEX_BITS-1:0]          hit_upd_index,
  input  logic [OUTPUT_BITS-1:0]         hit_upd_way,
  output logic                           hit_upd_stall,
  output logic [INDEX_BITS-1:0]          lru_line_selector,
  output logic [OUTPUT_BITS-1:0]         lru_referenced_set,
  output logic                           lru_update,
  input  logic [OUTPUT_BITS-1:0]         lru_way,
  output logic [OUTPUT_BITS-1:0]         victim_way,
  input  logic                           victim_dirty,
  input  logic [TAG_BITS-1:0]            victim_tag,
  output logic                           mem_wr_valid,
  input  logic                           mem_wr_ready,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_wr_addr,
  output logic                           mem_rd_valid,
  input  logic                           mem_rd_ready,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_rd_addr,
  input  logic                           mem_rd_resp_valid,
  input  logic [LINE_BITS-1:0]           mem_rd_resp_data,
  output logic                           fill_en,
  output logic [OUTPUT_BITS-1:0]         fill_way,
  output logic [INDEX_BITS-1:0]          fill_index,
  output logic [LINE_BITS-1:0]           fill_data,
  output logic [TAG_BITS-1:0]            fill_tag
`ifdef LRU_REFILL_PERF_EN
  ,
  output logic [31:0]                    perf_miss_cnt,
  output logic [31:0]                    perf_wb_cnt
`endif
);

  if (ASSOCIATIVITY < 2 || (1 << OUTPUT_BITS) < ASSOCIATIVITY) begin : g_bad_cfg
    $error("lru_refill_ctrl: OUTPUT_BITS too narrow for ASSOCIATIVITY");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_VICTIM, S_WB, S_RD, S_RD_WAIT, S_FILL, S_DONE
  } state_t;

  state_t                 state, state_nx;
  logic [INDEX_BITS-1:0]  idx_q;
  logic [TAG_BITS-1:0]    tag_q;
  logic [TAG_BITS-1:0]    wb_tag_q;
  logic [OUTPUT_BITS-1:0] way_q;
  logic [LINE_BITS-1:0]   data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx_q    <= '0;
      tag_q    <= '0;
      wb_tag_q <= '0;
      way_q    <= '0;
      data_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (miss_valid) begin
          idx_q <= miss_index;
          tag_q <= miss_tag;
        end
        S_VICTIM: begin
          way_q    <= lru_way;
          wb_tag_q <= victim_tag;
        end
        S_RD_WAIT: if (mem_rd_resp_valid) data_q <= mem_rd_resp_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx           = state;
    miss_ready         = 1'b0;
    miss_done          = 1'b0;
    hit_upd_stall      = 1'b0;
    lru_line_selector  = '0;
    lru_referenced_set = '0;
    lru_update         = 1'b0;
    victim_way         = '0;
    mem_wr_valid       = 1'b0;
    mem_wr_addr        = '0;
    mem_rd_valid       = 1'b0;
    mem_rd_addr        = '0;
    fill_en            = 1'b0;
    fill_way           = '0;
    fill_index         = '0;
    fill_data          = '0;
    fill_tag           = '0;
    case (state)
      S_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_nx = S_VICTIM;
      end
      S_VICTIM: begin
        lru_line_selector = idx_q;
        victim_way        = lru_way;
        state_nx          = victim_dirty ? S_WB : S_RD;
      end
      S_WB: begin
        mem_wr_valid = 1'b1;
        mem_wr_addr  = {wb_tag_q, idx_q};
        if (mem_wr_ready) state_nx = S_RD;
      end
      S_RD: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = {tag_q, idx_q};
        if (mem_rd_ready) state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: if (mem_rd_resp_valid) state_nx = S_FILL;
      S_FILL: begin
        fill_en            = 1'b1;
        fill_way           = way_q;
        fill_index         = idx_q;
        fill_data          = data_q;
        fill_tag           = tag_q;
        lru_update         = 1'b1;
        lru_line_selector  = idx_q;
        lru_referenced_set = way_q;
        state_nx           = S_DONE;
      end
      S_DONE: begin
        miss_done = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // VICTIM reads and FILL writes the LRU port, so hits must wait there.
    if (hit_upd_valid) begin
      if (state == S_VICTIM || state == S_FILL) begin
        hit_upd_stall = 1'b1;
      end else begin
        lru_update         = 1'b1;
        lru_line_selector  = hit_upd_index;
        lru_referenced_set = hit_upd_way;
      end
    end
  end

`ifdef LRU_REFILL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_miss_cnt <= '0;
      perf_wb_cnt   <= '0;
    end else begin
      if (state == S_IDLE && miss_valid && perf_miss_cnt != 32'hFFFF_FFFF)
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (state == S_WB && mem_wr_ready && perf_wb_cnt != 32'hFFFF_FFFF)
        perf_wb_cnt <= perf_wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lru_refill_ctrl.sv
// Bench for lru_refill_ctrl: a cycle-schedule model of each refill is compared against the DUT every cycle.
module tb_lru_refill_ctrl;
  localparam int IB = 8, OB = 2, TB = 20, LB = 256;
  localparam int P_IDLE = 0, P_VIC = 1, P_WB = 2, P_RD = 3, P_RDW = 4, P_FILL = 5, P_DONE = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic miss_valid, miss_ready, miss_done;
  logic [IB-1:0] miss_index;
  logic [TB-1:0] miss_tag;
  logic hit_upd_valid, hit_upd_stall;
  logic [IB-1:0] hit_upd_index;
  logic [OB-1:0] hit_upd_way;
  logic [IB-1:0] lru_line_selector;
  logic [OB-1:0] lru_referenced_set, lru_way, victim_way;
  logic lru_update, victim_dirty;
  logic [TB-1:0] victim_tag;
  logic mem_wr_valid, mem_wr_ready, mem_rd_valid, mem_rd_ready, mem_rd_resp_valid;
  logic [TB+IB-1:0] mem_wr_addr, mem_rd_addr;
  logic [LB-1:0] mem_rd_resp_data, fill_data;
  logic fill_en;
  logic [OB-1:0] fill_way;
  logic [IB-1:0] fill_index;
  logic [TB-1:0] fill_tag;
`ifdef LRU_REFILL_PERF_EN
  logic [31:0] perf_miss_cnt, perf_wb_cnt;
`endif

  lru_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_index(miss_index),
    .miss_tag(miss_tag), .miss_done(miss_done),
    .hit_upd_valid(hit_upd_valid), .hit_upd_index(hit_upd_index),
    .hit_upd_way(hit_upd_way), .hit_upd_stall(hit_upd_stall),
    .lru_line_selector(lru_line_selector), .lru_referenced_set(lru_referenced_set),
    .lru_update(lru_update), .lru_way(lru_way), .victim_way(victim_way),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rd_resp_valid(mem_rd_resp_valid), .mem_rd_resp_data(mem_rd_resp_data),
    .fill_en(fill_en), .fill_way(fill_way), .fill_index(fill_index),
    .fill_data(fill_data), .fill_tag(fill_tag)
`ifdef LRU_REFILL_PERF_EN
    , .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  bit chk_on = 0;

  // Current refill schedule: cycle numbers of each phase boundary.
  bit act = 0;
  bit m_dirty;
  logic [IB-1:0] m_idx;
  logic [TB-1:0] m_tag, v_tag;
  logic [OB-1:0] v_way;
  logic [LB-1:0] m_line;
  int t0, wb_end, rd_end, rw_end, fill_c, done_c, kill;

  task automatic chk(input string nm, input logic [LB-1:0] a, input logic [LB-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
    end
  endtask

  function automatic int phase(input int c);
    if (!act || c <= t0 || c > kill || c > done_c) return P_IDLE;
    if (c == t0 + 1) return P_VIC;
    if (m_dirty && c <= wb_end) return P_WB;
    if (c <= rd_end) return P_RD;
    if (c <= rw_end) return P_RDW;
    if (c == fill_c) return P_FILL;
    return P_DONE;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    miss_valid        = 1'b0;
    mem_wr_ready      = act && m_dirty && cyc == wb_end && cyc <= kill;
    mem_rd_ready      = act && cyc == rd_end && cyc <= kill;
    mem_rd_resp_valid = act && cyc == rw_end;
    mem_rd_resp_data  = m_line;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start_miss(input logic [IB-1:0] idx, input logic [TB-1:0] tag,
                            input logic [OB-1:0] way, input bit dirty, input logic [TB-1:0] vt,
                            input int wrw, input int rdw, input int rsw, input logic [LB-1:0] line);
    m_idx = idx; m_tag = tag; v_way = way; m_dirty = dirty; v_tag = vt; m_line = line;
    t0     = cyc;
    wb_end = t0 + 2 + wrw;
    rd_end = (dirty ? wb_end + 1 : t0 + 2) + rdw;
    rw_end = rd_end + 1 + rsw;
    fill_c = rw_end + 1;
    done_c = rw_end + 2;
    kill   = 1 << 30;
    act    = 1;
    miss_valid = 1'b1; miss_index = idx; miss_tag = tag;
    lru_way = way; victim_dirty = dirty; victim_tag = vt;
  endtask

  always @(negedge clk) begin
    int ph;
    bit own;
    logic e_upd, e_stall;
    logic [IB-1:0] e_sel;
    logic [OB-1:0] e_ref;
    if (chk_on) begin
      ph  = phase(cyc);
      own = (ph == P_VIC) || (ph == P_FILL);
      e_upd = 0; e_stall = 0; e_sel = '0; e_ref = '0;
      if (own) begin
        e_sel   = m_idx;
        e_upd   = (ph == P_FILL);
        e_ref   = (ph == P_FILL) ? v_way : '0;
        e_stall = hit_upd_valid;
      end else if (hit_upd_valid) begin
        e_upd = 1; e_sel = hit_upd_index; e_ref = hit_upd_way;
      end
      chk("miss_ready", miss_ready, ph == P_IDLE);
      chk("miss_done", miss_done, ph == P_DONE);
      chk("victim_way", victim_way, ph == P_VIC ? v_way : '0);
      chk("mem_wr_valid", mem_wr_valid, ph == P_WB);
      chk("mem_wr_addr", mem_wr_addr, ph == P_WB ? {v_tag, m_idx} : '0);
      chk("mem_rd_valid", mem_rd_valid, ph == P_RD);
      chk("mem_rd_addr", mem_rd_addr, ph == P_RD ? {m_tag, m_idx} : '0);
      chk("fill_en", fill_en, ph == P_FILL);
      chk("fill_way", fill_way, ph == P_FILL ? v_way : '0);
      chk("fill_index", fill_index, ph == P_FILL ? m_idx : '0);
      chk("fill_tag", fill_tag, ph == P_FILL ? m_tag : '0);
      chk("fill_data", fill_data, ph == P_FILL ? m_line : '0);
      chk("lru_update", lru_update, e_upd);
      chk("lru_line_selector", lru_line_selector, e_sel);
      chk("lru_referenced_set", lru_referenced_set, e_ref);
      chk("hit_upd_stall", hit_upd_stall, e_stall);
    end
  end

  initial begin
    rst_n = 1'b0; miss_valid = 0; miss_index = '0; miss_tag = '0;
    hit_upd_valid = 0; hit_upd_index = '0; hit_upd_way = '0;
    lru_way = '0; victim_dirty = 0; victim_tag = '0;
    mem_wr_ready = 0; mem_rd_ready = 0; mem_rd_resp_valid = 0; mem_rd_resp_data = '0;
    m_line = '0; m_idx = '0; m_tag = '0; v_tag = '0; v_way = '0; m_dirty = 0;
    t0 = 0; wb_end = 0; rd_end = 0; rw_end = 0; fill_c = 0; done_c = 0; kill = 0;
    tick(); chk_on = 1;
    tick(); tick(); rst_n = 1'b1;
    #3 chk("lit_rst_miss_ready", miss_ready, 1);
    chk("lit_rst_lru_update", lru_update, 0);

    // hit update while idle
    tick(); hit_upd_valid = 1; hit_upd_index = 8'h40; hit_upd_way = 2'd1;
    #3 chk("lit_idle_hit_upd", lru_update, 1);
    chk("lit_idle_hit_sel", lru_line_selector, 8'h40);
    chk("lit_idle_hit_ref", lru_referenced_set, 1);
    tick(); hit_upd_valid = 0;

    // clean victim, zero-wait memory
    tick();
    start_miss(8'h12, 20'h12345, 2'd2, 0, 20'h0, 0, 0, 0, {8{32'hC0DE_0001}});
    run_to(t0 + 2);
    #3 chk("lit_clean_rd_addr", mem_rd_addr, {20'h12345, 8'h12});
    run_to(t0 + 4);
    #3 chk("lit_clean_fill_en", fill_en, 1);
    chk("lit_clean_fill_way", fill_way, 2);
    chk("lit_clean_lru_ref", lru_referenced_set, 2);
    run_to(t0 + 5);
    #3 chk("lit_clean_done", miss_done, 1);
    tick();

    // dirty victim, slow writeback, hits in RD_WAIT and FILL
    start_miss(8'h7F, 20'h55555, 2'd3, 1, 20'hABCDE, 3, 1, 2, {8{32'h1234_5678}});
    run_to(t0 + 2);
    #3 chk("lit_wb_addr", mem_wr_addr, {20'hABCDE, 8'h7F});
    run_to(t0 + 5);
    #3 chk("lit_wb_last_valid", mem_wr_valid, 1);
    run_to(t0 + 6);
    #3 chk("lit_wb_then_rd", mem_rd_valid, 1);
    run_to(rd_end + 1);
    hit_upd_valid = 1; hit_upd_index = 8'h40; hit_upd_way = 2'd1;
    #3 chk("lit_rdw_hit_sel", lru_line_selector, 8'h40);
    tick(); hit_upd_valid = 0;
    run_to(fill_c);
    hit_upd_valid = 1; hit_upd_index = 8'h33; hit_upd_way = 2'd0;
    #3 chk("lit_fill_stall", hit_upd_stall, 1);
    chk("lit_fill_ref", lru_referenced_set, 3);
    tick();
    #3 chk("lit_held_hit_fwd", lru_line_selector, 8'h33);
    chk("lit_held_hit_stall", hit_upd_stall, 0);
    tick(); hit_upd_valid = 0;

    // reset during RD_WAIT, then a late response
    start_miss(8'h21, 20'h0F0F0, 2'd1, 0, 20'h0, 0, 0, 3, {8{32'hDEAD_BEEF}});
    run_to(t0 + 3);
    rst_n = 1'b0; kill = cyc;
    tick(); rst_n = 1'b1;
    #3 chk("lit_abort_idle", miss_ready, 1);
    run_to(rw_end + 1);
    #3 chk("lit_abort_no_fill", fill_en, 0);
    tick();

    // three misses for the counters; hit during VICTIM
    start_miss(8'hFF, 20'hFFFFF, 2'd0, 0, 20'h0, 0, 2, 1, {8{32'hA5A5_5A5A}});
    tick(); hit_upd_valid = 1; hit_upd_index = 8'h01; hit_upd_way = 2'd3;
    #3 chk("lit_vic_stall", hit_upd_stall, 1);
    tick(); hit_upd_valid = 0;
    run_to(done_c + 1);
    start_miss(8'h00, 20'h00002, 2'd1, 1, 20'h00001, 0, 0, 0, {8{32'h0F0F_F0F0}});
    run_to(done_c + 1);
    start_miss(8'h80, 20'h80808, 2'd3, 0, 20'h0, 0, 0, 0, {8{32'h7777_1111}});
    run_to(done_c + 3);
`ifdef LRU_REFILL_PERF_EN
    #3 chk("perf_miss_cnt", perf_miss_cnt, 3);
    chk("perf_wb_cnt", perf_wb_cnt, 1);
`endif
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
